// File: rtl/camada_pkg.sv
// Shared types and helpers for the camada_mac_seq layer.
// Optional feature macro used by this layer: CAMADA_SAT_FLAG_EN.
package camada_pkg;

  typedef enum logic [1:0] {
    FA_LIN  = 2'd0,
    FA_RELU = 2'd1,
    FA_STEP = 2'd2
  } fa_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    MAC,
    ACT,
    HOLD
  } state_t;

  // Never returns less than 1 so that port and counter widths stay legal.
  function automatic int clog2(input int v);
    int r;
    int p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p * 2;
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Accumulator width large enough that NI_MAX full-scale products plus a bias cannot overflow.
  function automatic int accw(input int xw, input int ww, input int ni);
    return xw + ww + clog2(ni) + 1;
  endfunction

  function automatic logic signed [63:0] sat(input logic signed [63:0] a, input int ow);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    if (a > hi) return hi;
    if (a < lo) return lo;
    return a;
  endfunction

endpackage

// File: rtl/mac_neuronio.sv
// One neuron of camada_mac_seq: serial accumulator, enable gate and activation/saturation stage.
// With CAMADA_SAT_FLAG_EN defined it also reports whether the registered result was clamped.
module mac_neuronio
  import camada_pkg::*;
#(
  parameter int XW   = 8,
  parameter int WW   = 16,
  parameter int OW   = 8,
  parameter int FRAC = 6,
  parameter int ACCW = 30
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 acc_en,
  input  logic                 act_en,
`ifdef CAMADA_SAT_FLAG_EN
  input  logic                 clear_sat,
  output logic                 sat_flag,
`endif
  input  logic                 flag_bias,
  input  logic signed [WW-1:0] bias,
  input  logic signed [XW-1:0] x,
  input  logic signed [WW-1:0] w,
  input  fa_t                  fa,
  input  logic                 en,
  output logic signed [OW-1:0] r
);

  logic signed [ACCW-1:0]    acc_q, acc_d;
  logic signed [XW+WW-1:0]   prod;
  logic signed [ACCW-1:0]    act_in;
  logic signed [63:0]        raw64;
  logic signed [63:0]        res64;
  logic signed [OW-1:0]      r_q, r_d;

  assign prod   = (XW+WW)'(x) * (XW+WW)'(w);
  assign act_in = acc_q >>> FRAC;

  always_comb begin
    acc_d = acc_q;
    if (load) begin
      acc_d = flag_bias ? ACCW'(bias) : '0;
    end else if (acc_en) begin
      acc_d = acc_q + ACCW'(prod);
    end
  end

  // raw64 is the activation before clamping; comparing it with res64 reveals saturation.
  always_comb begin
    raw64 = 64'(act_in);
    case (fa)
      FA_RELU: if (act_in < 0) raw64 = '0;
      FA_STEP: raw64 = (act_in < 0) ? 64'sd0 : (64'sd1 <<< FRAC);
      default: ;
    endcase
    res64 = sat(raw64, OW);
  end

  always_comb begin
    r_d = r_q;
    if (act_en) begin
      r_d = en ? OW'(res64) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      r_q   <= '0;
    end else begin
      acc_q <= acc_d;
      r_q   <= r_d;
    end
  end

  assign r = r_q;

`ifdef CAMADA_SAT_FLAG_EN
  logic sat_q, sat_d;

  always_comb begin
    sat_d = sat_q;
    if (clear_sat) begin
      sat_d = 1'b0;
    end else if (act_en) begin
      sat_d = en && (res64 != raw64);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) sat_q <= 1'b0;
    else     sat_q <= sat_d;
  end

  assign sat_flag = sat_q;
`endif

endmodule

// File: rtl/camada_mac_seq.sv
// Sequential neural layer: N_NEUR serial-MAC neurons sharing one input vector and a streamed weight memory.
// Define CAMADA_SAT_FLAG_EN to add the per-neuron saturation flag port oSat.
module camada_mac_seq
  import camada_pkg::*;
#(
  parameter int N_NEUR = 20,
  parameter int NI_MAX = 20,
  parameter int XW     = 8,
  parameter int WW     = 16,
  parameter int OW     = 8,
  parameter int FRAC   = 6,
  localparam int KW    = clog2(NI_MAX + 1),
  localparam int AW    = clog2(NI_MAX)
) (
  input  logic                   clk,
  input  logic                   iRst,
  input  logic                   iStart,
  input  logic [NI_MAX*XW-1:0]   ix,
  input  logic [N_NEUR*WW-1:0]   iBias,
  input  logic                   iFlagBias,
  input  logic [1:0]             iCtrlFA,
  input  logic [N_NEUR-1:0]      iEn,
  input  logic [KW-1:0]          iQtdEntradas,
  output logic [AW-1:0]          oWAddr,
  input  logic [N_NEUR*WW-1:0]   iW,
  output logic [N_NEUR*OW-1:0]   oR,
  output logic                   oValid,
  input  logic                   iReady,
`ifdef CAMADA_SAT_FLAG_EN
  output logic [N_NEUR-1:0]      oSat,
`endif
  output logic                   oBusy
);

  localparam int ACCW = accw(XW, WW, NI_MAX);

  state_t               state_q, state_d;
  logic [AW-1:0]        waddr_q, waddr_d;
  logic [KW-1:0]        cnt_q, cnt_d;
  logic [KW-1:0]        k_q, k_d;
  logic signed [XW-1:0] x_q [NI_MAX];
  logic signed [XW-1:0] x_d [NI_MAX];
  logic [N_NEUR-1:0]    en_q, en_d;
  fa_t                  fa_q, fa_d;
  logic                 valid_q, valid_d;
  logic                 load, acc_en, act_en, leave_hold;
  logic [KW:0]          waddr_nxt, cnt_nxt;
  logic                 more_addr, last_prod;
  logic [KW-1:0]        k_in;
  fa_t                  fa_in;

  assign k_in      = (iQtdEntradas > KW'(NI_MAX)) ? KW'(NI_MAX) : iQtdEntradas;
  assign waddr_nxt = {{(KW+1-AW){1'b0}}, waddr_q} + (KW+1)'(1);
  assign cnt_nxt   = {1'b0, cnt_q} + (KW+1)'(1);
  assign more_addr = waddr_nxt < {1'b0, k_q};
  assign last_prod = cnt_nxt == {1'b0, k_q};

  always_comb begin
    case (iCtrlFA)
      2'b01:   fa_in = FA_RELU;
      2'b10:   fa_in = FA_STEP;
      default: fa_in = FA_LIN;
    endcase
  end

  // The weight address runs one cycle ahead of the product index because the memory read is registered.
  always_comb begin
    state_d    = state_q;
    waddr_d    = waddr_q;
    cnt_d      = cnt_q;
    k_d        = k_q;
    x_d        = x_q;
    en_d       = en_q;
    fa_d       = fa_q;
    valid_d    = valid_q;
    load       = 1'b0;
    acc_en     = 1'b0;
    act_en     = 1'b0;
    leave_hold = 1'b0;
    case (state_q)
      IDLE: begin
        if (iStart) begin
          load    = 1'b1;
          waddr_d = '0;
          cnt_d   = '0;
          k_d     = k_in;
          en_d    = iEn;
          fa_d    = fa_in;
          for (int i = 0; i < NI_MAX; i++) x_d[i] = ix[i*XW +: XW];
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (more_addr) waddr_d = waddr_nxt[AW-1:0];
        state_d = (k_q == '0) ? ACT : MAC;
      end
      MAC: begin
        acc_en = 1'b1;
        if (more_addr) waddr_d = waddr_nxt[AW-1:0];
        if (last_prod) state_d = ACT;
        else           cnt_d   = cnt_nxt[KW-1:0];
      end
      ACT: begin
        act_en  = 1'b1;
        valid_d = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (iReady) begin
          leave_hold = 1'b1;
          valid_d    = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (iRst) begin
      state_q <= IDLE;
      waddr_q <= '0;
      cnt_q   <= '0;
      k_q     <= '0;
      en_q    <= '0;
      fa_q    <= FA_LIN;
      valid_q <= 1'b0;
      for (int i = 0; i < NI_MAX; i++) x_q[i] <= '0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      en_q    <= en_d;
      fa_q    <= fa_d;
      valid_q <= valid_d;
      x_q     <= x_d;
    end
  end

  for (genvar g = 0; g < N_NEUR; g++) begin : g_neur
    mac_neuronio #(
      .XW  (XW),
      .WW  (WW),
      .OW  (OW),
      .FRAC(FRAC),
      .ACCW(ACCW)
    ) u_neur (
      .clk      (clk),
      .rst      (iRst),
      .load     (load),
      .acc_en   (acc_en),
      .act_en   (act_en),
`ifdef CAMADA_SAT_FLAG_EN
      .clear_sat(leave_hold),
      .sat_flag (oSat[g]),
`endif
      .flag_bias(iFlagBias),
      .bias     (iBias[g*WW +: WW]),
      .x        (x_q[cnt_q[AW-1:0]]),
      .w        (iW[g*WW +: WW]),
      .fa       (fa_q),
      .en       (en_q[g]),
      .r        (oR[g*OW +: OW])
    );
  end

`ifndef CAMADA_SAT_FLAG_EN
  logic unused_leave_hold;
  assign unused_leave_hold = leave_hold;
`endif

  assign oWAddr = waddr_q;
  assign oValid = valid_q;
  assign oBusy  = (state_q != IDLE);

endmodule

// File: tb/tb_camada_mac_seq.sv
// Self-checking bench for camada_mac_seq (N_NEUR=4): vector table, hand-written corner sequences, random transactions.
// Checks oSat as well when CAMADA_SAT_FLAG_EN is defined.
module tb_camada_mac_seq;

  localparam int N_NEUR = 4;
  localparam int NI_MAX = 20;
  localparam int XW     = 8;
  localparam int WW     = 16;
  localparam int OW     = 8;
  localparam int FRAC   = 6;
  localparam int KW     = 5;
  localparam int AW     = 5;

  logic                 clk;
  logic                 iRst;
  logic                 iStart;
  logic [NI_MAX*XW-1:0] ix;
  logic [N_NEUR*WW-1:0] iBias;
  logic                 iFlagBias;
  logic [1:0]           iCtrlFA;
  logic [N_NEUR-1:0]    iEn;
  logic [KW-1:0]        iQtdEntradas;
  logic [AW-1:0]        oWAddr;
  logic [N_NEUR*WW-1:0] iW;
  logic [N_NEUR*OW-1:0] oR;
  logic                 oValid;
  logic                 iReady;
  logic                 oBusy;
`ifdef CAMADA_SAT_FLAG_EN
  logic [N_NEUR-1:0]    oSat;
`endif

  camada_mac_seq #(
    .N_NEUR(N_NEUR), .NI_MAX(NI_MAX), .XW(XW), .WW(WW), .OW(OW), .FRAC(FRAC)
  ) dut (
    .clk         (clk),
    .iRst        (iRst),
    .iStart      (iStart),
    .ix          (ix),
    .iBias       (iBias),
    .iFlagBias   (iFlagBias),
    .iCtrlFA     (iCtrlFA),
    .iEn         (iEn),
    .iQtdEntradas(iQtdEntradas),
    .oWAddr      (oWAddr),
    .iW          (iW),
    .oR          (oR),
    .oValid      (oValid),
    .iReady      (iReady),
`ifdef CAMADA_SAT_FLAG_EN
    .oSat        (oSat),
`endif
    .oBusy       (oBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous weight memory: data for oWAddr appears one cycle later.
  logic [N_NEUR*WW-1:0] wmem [NI_MAX];
  always @(posedge clk) iW <= wmem[oWAddr];

  int total;
  int bad;

  int          cur_x [NI_MAX];
  int          cur_w [NI_MAX][N_NEUR];
  int          cur_bias [N_NEUR];
  int          cur_k;
  bit          cur_flag;
  bit [1:0]    cur_fa;
  bit [N_NEUR-1:0] cur_en;
  longint      exp_r [N_NEUR];
  bit          exp_s [N_NEUR];

  typedef struct {
    int       k;
    int       xv;
    int       wv;
    int       bias;
    bit       flag;
    bit [1:0] fa;
    bit [3:0] en;
    int       er;
    bit       es;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input longint act, input longint expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic int getR(input int n);
    logic [OW-1:0] v;
    v = oR[n*OW +: OW];
    return int'($signed(v));
  endfunction

  function automatic longint clampOW(input longint v);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (OW - 1)) - 1;
    lo = -(hi + 1);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Reference: whole dot product in 64-bit arithmetic, then shift, activation and clamp.
  function automatic longint modelNeuron(input int n, output bit s);
    int     k;
    longint acc;
    longint a;
    longint raw;
    longint r;
    k   = (cur_k > NI_MAX) ? NI_MAX : cur_k;
    acc = cur_flag ? longint'(cur_bias[n]) : 0;
    for (int i = 0; i < k; i++) acc += longint'(cur_x[i]) * longint'(cur_w[i][n]);
    a = acc >>> FRAC;
    case (cur_fa)
      2'b01:   raw = (a < 0) ? 0 : a;
      2'b10:   raw = (a < 0) ? 0 : (longint'(1) <<< FRAC);
      default: raw = a;
    endcase
    r = clampOW(raw);
    s = cur_en[n] && (r != raw);
    if (!cur_en[n]) r = 0;
    return r;
  endfunction

  task automatic loadStim();
    for (int i = 0; i < NI_MAX; i++) ix[i*XW +: XW] = XW'(cur_x[i]);
    for (int n = 0; n < N_NEUR; n++) iBias[n*WW +: WW] = WW'(cur_bias[n]);
    for (int i = 0; i < NI_MAX; i++)
      for (int n = 0; n < N_NEUR; n++) wmem[i][n*WW +: WW] = WW'(cur_w[i][n]);
    iFlagBias    = cur_flag;
    iCtrlFA      = cur_fa;
    iEn          = cur_en;
    iQtdEntradas = KW'(cur_k);
  endtask

  // Starts a transaction, scrambles the operand inputs after accept, and waits for oValid.
  task automatic applyStimulus(output int lat, output bit timedOut);
    @(negedge clk);
    loadStim();
    iStart = 1'b1;
    @(negedge clk);
    iStart       = 1'b0;
    ix           = {NI_MAX{8'($urandom)}};
    iBias        = {N_NEUR{16'($urandom)}};
    iFlagBias    = 1'($urandom);
    iCtrlFA      = 2'($urandom);
    iEn          = N_NEUR'($urandom);
    iQtdEntradas = KW'($urandom);
    lat = 0;
    while (!oValid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    timedOut = !oValid;
  endtask

  task automatic checkOutput(input string tag, input int lat, input bit timedOut);
    int k;
    k = (cur_k > NI_MAX) ? NI_MAX : cur_k;
    if (timedOut) begin
      total++;
      bad++;
      $display("[TB] FAIL %s_timeout: oValid=%0d after %0d cycles, required 1", tag, oValid, lat);
    end
    check($sformatf("%s_latency", tag), lat, k + 2);
    check($sformatf("%s_busy", tag), oBusy, 1);
    for (int n = 0; n < N_NEUR; n++) begin
      check($sformatf("%s_r%0d", tag, n), getR(n), exp_r[n]);
`ifdef CAMADA_SAT_FLAG_EN
      check($sformatf("%s_sat%0d", tag, n), oSat[n], exp_s[n]);
`endif
    end
  endtask

  task automatic releaseHold(input string tag);
    iReady = 1'b1;
    @(negedge clk);
    iReady = 1'b0;
    check($sformatf("%s_valid_drop", tag), oValid, 0);
    check($sformatf("%s_idle", tag), oBusy, 0);
`ifdef CAMADA_SAT_FLAG_EN
    check($sformatf("%s_sat_clear", tag), oSat, 0);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int       lat;
    bit       to;
    int       snap [N_NEUR];
    bit       sawValid;
    bit       sdummy;

    total = 0;
    bad   = 0;
    iRst = 1'b1; iStart = 1'b0; iReady = 1'b0; ix = '0; iBias = '0;
    iFlagBias = 1'b0; iCtrlFA = 2'b00; iEn = '0; iQtdEntradas = '0;
    for (int i = 0; i < NI_MAX; i++) wmem[i] = '0;

    // Reset held for three cycles
    repeat (3) @(negedge clk);
    check("reset_oR", oR, 0);
    check("reset_oValid", oValid, 0);
    check("reset_oBusy", oBusy, 0);
    check("reset_oWAddr", oWAddr, 0);
    iRst = 1'b0;

    // K=3, x={1,2,3}, w=64: address sequence and result timing
    for (int i = 0; i < NI_MAX; i++) begin
      cur_x[i] = (i < 3) ? i + 1 : 0;
      for (int n = 0; n < N_NEUR; n++) cur_w[i][n] = 64;
    end
    for (int n = 0; n < N_NEUR; n++) cur_bias[n] = 0;
    cur_k = 3; cur_flag = 0; cur_fa = 2'b00; cur_en = '1;
    @(negedge clk);
    loadStim();
    iStart = 1'b1;
    @(negedge clk);
    iStart = 1'b0;
    check("k3_waddr_e0", oWAddr, 0);
    @(negedge clk);
    check("k3_waddr_e1", oWAddr, 1);
    @(negedge clk);
    check("k3_waddr_e2", oWAddr, 2);
    @(negedge clk);
    check("k3_valid_e3", oValid, 0);
    @(negedge clk);
    check("k3_valid_e4", oValid, 0);
    @(negedge clk);
    check("k3_valid_e5", oValid, 1);
    for (int n = 0; n < N_NEUR; n++) check($sformatf("k3_r%0d", n), getR(n), 6);
    releaseHold("k3");

    // Uniform-operand vectors: {K, x, w, bias, flag, fa, en, expected oR, expected sat}
    vecs[0]  = '{1,   1,   -64,   0,    1'b0, 2'b00, 4'hF,    -1,   1'b0};
    vecs[1]  = '{1,   1,   -64,   0,    1'b0, 2'b01, 4'hF,     0,   1'b0};
    vecs[2]  = '{1,   1,   -64,   0,    1'b0, 2'b10, 4'hF,     0,   1'b0};
    vecs[3]  = '{1,   1,    64,   0,    1'b0, 2'b10, 4'hF,    64,   1'b0};
    vecs[4]  = '{20,  127, 32767, 0,    1'b0, 2'b00, 4'hF,   127,   1'b1};
    vecs[5]  = '{20, -128, 32767, 0,    1'b0, 2'b00, 4'hF,  -128,   1'b1};
    vecs[6]  = '{0,   0,     0,   128,  1'b1, 2'b00, 4'b0101,  2,   1'b0};
    vecs[7]  = '{25,  1,    64,   0,    1'b0, 2'b00, 4'hF,    20,   1'b0};
    vecs[8]  = '{2,   3,   100,   0,    1'b0, 2'b01, 4'hF,     9,   1'b0};
    vecs[9]  = '{1,  -1,     1,   0,    1'b0, 2'b00, 4'hF,    -1,   1'b0};
    vecs[10] = '{1,   1,    64,  -640,  1'b1, 2'b00, 4'hF,    -9,   1'b0};
    vecs[11] = '{1,   1,   -64,   0,    1'b0, 2'b11, 4'hF,    -1,   1'b0};
    vecs[12] = '{20,  127, 32767, 0,    1'b0, 2'b01, 4'hF,   127,   1'b1};
    vecs[13] = '{0,   0,     0,   -1,   1'b1, 2'b10, 4'hF,     0,   1'b0};

    for (int v = 0; v < 14; v++) begin
      for (int i = 0; i < NI_MAX; i++) begin
        cur_x[i] = vecs[v].xv;
        for (int n = 0; n < N_NEUR; n++) cur_w[i][n] = vecs[v].wv;
      end
      for (int n = 0; n < N_NEUR; n++) begin
        cur_bias[n] = vecs[v].bias;
        exp_r[n]    = vecs[v].en[n] ? longint'(vecs[v].er) : 0;
        exp_s[n]    = vecs[v].en[n] && vecs[v].es;
      end
      cur_k = vecs[v].k; cur_flag = vecs[v].flag; cur_fa = vecs[v].fa; cur_en = vecs[v].en;
      applyStimulus(lat, to);
      checkOutput($sformatf("vec%0d", v), lat, to);
      releaseHold($sformatf("vec%0d", v));
    end

    // HOLD with iReady low: iStart pulses ignored, outputs stable
    for (int i = 0; i < NI_MAX; i++) begin
      cur_x[i] = 2;
      for (int n = 0; n < N_NEUR; n++) cur_w[i][n] = 64 * (n + 1);
    end
    cur_k = 2; cur_flag = 0; cur_fa = 2'b00; cur_en = '1;
    for (int n = 0; n < N_NEUR; n++) begin
      cur_bias[n] = 0;
      snap[n] = 4 * (n + 1);
    end
    applyStimulus(lat, to);
    for (int c = 0; c < 10; c++) begin
      iStart = (c % 3 == 0);
      @(negedge clk);
      check($sformatf("hold_valid_c%0d", c), oValid, 1);
      check($sformatf("hold_busy_c%0d", c), oBusy, 1);
      for (int n = 0; n < N_NEUR; n++) check($sformatf("hold_r%0d_c%0d", n, c), getR(n), snap[n]);
    end
    iStart = 1'b1;
    iReady = 1'b1;
    @(negedge clk);
    iStart = 1'b0;
    iReady = 1'b0;
    check("hold_exit_valid", oValid, 0);
    check("hold_exit_busy", oBusy, 0);
    @(negedge clk);
    check("hold_no_restart", oBusy, 0);

    // Reset during MAC: abort with no output
    for (int i = 0; i < NI_MAX; i++) begin
      cur_x[i] = 5;
      for (int n = 0; n < N_NEUR; n++) cur_w[i][n] = 1000;
    end
    cur_k = 20;
    @(negedge clk);
    loadStim();
    iStart = 1'b1;
    @(negedge clk);
    iStart = 1'b0;
    repeat (5) @(negedge clk);
    check("midmac_busy", oBusy, 1);
    iRst = 1'b1;
    @(negedge clk);
    iRst = 1'b0;
    check("abort_busy", oBusy, 0);
    check("abort_valid", oValid, 0);
    check("abort_oR", oR, 0);
    check("abort_waddr", oWAddr, 0);
    sawValid = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (oValid) sawValid = 1'b1;
    end
    check("abort_never_valid", sawValid, 0);

    // Random transactions against the reference model
    for (int t = 0; t < 40; t++) begin
      int d;
      cur_k    = $urandom_range(0, 24);
      cur_flag = 1'($urandom);
      cur_fa   = 2'($urandom);
      cur_en   = N_NEUR'($urandom);
      for (int i = 0; i < NI_MAX; i++) begin
        cur_x[i] = int'($urandom_range(0, 255)) - 128;
        for (int n = 0; n < N_NEUR; n++) cur_w[i][n] = int'($urandom_range(0, 65535)) - 32768;
      end
      for (int n = 0; n < N_NEUR; n++) begin
        cur_bias[n] = int'($urandom_range(0, 65535)) - 32768;
        exp_r[n]    = modelNeuron(n, sdummy);
        exp_s[n]    = sdummy;
      end
      applyStimulus(lat, to);
      checkOutput($sformatf("rnd%0d", t), lat, to);
      d = $urandom_range(0, 3);
      for (int c = 0; c < d; c++) begin
        @(negedge clk);
        check($sformatf("rnd%0d_hold_valid", t), oValid, 1);
        check($sformatf("rnd%0d_hold_r0", t), getR(0), exp_r[0]);
      end
      releaseHold($sformatf("rnd%0d", t));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
